fetch_stage_mt: RTL and testbench

Multithreaded instruction fetch stage for the Arya core, the parametrised successor to the single-thread PC incrementor and fetch path. It keeps one program counter per hardware thread and issues fetches round-robin on memory port A. It absorbs decode back-pressure with a one-entry skid buffer, applies per-thread branch redirects with squash, and shares port A with the debug setup/verify access path. It sits between the dual-port instruction/data memory and the fetch/decode pipeline register.

---
 rtl/arya_fetch_pkg.sv | 24 ++
 rtl/fetch_stage_mt_arb.sv | 34 +++
 rtl/fetch_stage_mt.sv | 136 +++++++++++++
 tb/tb_fetch_stage_mt.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arya_fetch_pkg.sv
// Shared types and helpers for the Arya multithreaded fetch stage.
package arya_fetch_pkg;

    localparam int TAG_TID_W = 4;
    localparam int TAG_PC_W  = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_TID_W-1:0] tid;
        logic [TAG_PC_W-1:0]  pc;
    } fetch_tag_t;

    function automatic int calc_tw(input int num_threads);
        return (num_threads <= 2) ? 1 : $clog2(num_threads);
    endfunction

    // Each thread starts at the base of its own equal slice of the PC space.
    function automatic logic [TAG_PC_W-1:0] reset_pc(input int tid, input int pc_w, input int tw);
        logic [TAG_PC_W-1:0] v;
        v = TAG_PC_W'(tid) << (pc_w - tw);
        return v;
    endfunction

endpackage

// File: rtl/fetch_stage_mt_arb.sv
// Round-robin selector: first active thread at or after the pointer.
module fetch_rr_arbiter
    import arya_fetch_pkg::*;
#(
    parameter  int NUM_THREADS = 4,
    localparam int TW          = calc_tw(NUM_THREADS)
) (
    input  logic [TW-1:0]          ptr,
    input  logic [NUM_THREADS-1:0] mask,
    input  logic                   hold,
    output logic [TW-1:0]          sel,
    output logic                   any_active,
    output logic [TW-1:0]          next_ptr
);

    logic [TW-1:0] idx;

    // Scan from the farthest offset down so the nearest active thread wins.
    always_comb begin
        sel        = ptr;
        any_active = 1'b0;
        idx        = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            idx = TW'((int'(ptr) + i) % NUM_THREADS);
            if (mask[idx]) begin
                sel        = idx;
                any_active = 1'b1;
            end
        end
    end

    assign next_ptr = hold ? ptr : TW'((int'(sel) + 1) % NUM_THREADS);

endmodule

// File: rtl/fetch_stage_mt.sv
// Multithreaded round-robin fetch stage with skid buffer, redirect squash and debug port sharing.
// Optional build macro ARYA_THREAD_MASK_EN adds the thread_active input.
module fetch_stage_mt
    import arya_fetch_pkg::*;
#(
    parameter  int INST_ADDR_WIDTH = 9,
    parameter  int MEM_ADDR_WIDTH  = 10,
    parameter  int DATAPATH_WIDTH  = 64,
    parameter  int NUM_THREADS     = 4,
    localparam int TW              = calc_tw(NUM_THREADS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       stall,
`ifdef ARYA_THREAD_MASK_EN
    input  logic [NUM_THREADS-1:0]     thread_active,
`endif
    input  logic                       redirect_valid,
    input  logic [TW-1:0]              redirect_tid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    input  logic                       dbg_req,
    input  logic                       dbg_we,
    input  logic [MEM_ADDR_WIDTH-1:0]  dbg_addr,
    input  logic [DATAPATH_WIDTH-1:0]  dbg_wdata,
    output logic [DATAPATH_WIDTH-1:0]  dbg_rdata,
    output logic                       dbg_rvalid,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic                       mem_we,
    output logic [DATAPATH_WIDTH-1:0]  mem_din,
    input  logic [DATAPATH_WIDTH-1:0]  mem_dout,
    output logic                       inst_valid,
    output logic [DATAPATH_WIDTH-1:0]  inst_out,
    output logic [INST_ADDR_WIDTH-1:0] inst_pc,
    output logic [TW-1:0]              inst_tid
);

    logic [INST_ADDR_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [TW-1:0]              rr_ptr, sel, next_ptr;
    logic [NUM_THREADS-1:0]     active_mask;
    logic                       any_active, issue_ok, redir_hit, issue, hold_ptr;
    fetch_tag_t                 fl_tag_p1, skid_tag_p1;
    logic [DATAPATH_WIDTH-1:0]  skid_data_p1;
    logic                       fl_live, skid_live;
    logic                       unused_tag_bits;

`ifdef ARYA_THREAD_MASK_EN
    assign active_mask = thread_active;
`else
    assign active_mask = '1;
`endif

    fetch_rr_arbiter #(.NUM_THREADS(NUM_THREADS)) u_arb (
        .ptr        (rr_ptr),
        .mask       (active_mask),
        .hold       (hold_ptr),
        .sel        (sel),
        .any_active (any_active),
        .next_ptr   (next_ptr)
    );

    // Stage p0: issue decision and port A mux
    assign fl_live   = fl_tag_p1.valid &
                       ~(redirect_valid & (fl_tag_p1.tid == TAG_TID_W'(redirect_tid)));
    assign skid_live = skid_tag_p1.valid &
                       ~(redirect_valid & (skid_tag_p1.tid == TAG_TID_W'(redirect_tid)));
    assign issue_ok  = en & ~stall & ~dbg_req & ~skid_tag_p1.valid & any_active;
    assign redir_hit = redirect_valid & (redirect_tid == sel);
    assign issue     = issue_ok & ~redir_hit;
    assign hold_ptr  = ~issue;

    assign mem_addr  = dbg_req ? dbg_addr : MEM_ADDR_WIDTH'(pc_q[sel]);
    assign mem_we    = dbg_req & dbg_we;
    assign mem_din   = dbg_req ? dbg_wdata : '0;
    assign dbg_rdata = mem_dout;

    assign unused_tag_bits = ^{fl_tag_p1, skid_tag_p1};

    // Stage p1 (in-flight tag, skid) and p2 (output regs)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc_q[t] <= INST_ADDR_WIDTH'(reset_pc(t, INST_ADDR_WIDTH, TW));
            rr_ptr      <= '0;
            fl_tag_p1   <= '0;
            skid_tag_p1 <= '0;
            dbg_rvalid  <= 1'b0;
            inst_valid  <= 1'b0;
            inst_out    <= '0;
            inst_pc     <= '0;
            inst_tid    <= '0;
        end else begin
            dbg_rvalid <= dbg_req & ~dbg_we;
            rr_ptr     <= next_ptr;
            // Redirects are honoured even while en is low so none is ever lost.
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_valid && redirect_tid == TW'(t))
                    pc_q[t] <= redirect_pc;
                else if (issue && sel == TW'(t))
                    pc_q[t] <= pc_q[t] + 1'b1;
            end

            fl_tag_p1.valid <= issue;
            fl_tag_p1.tid   <= TAG_TID_W'(sel);
            fl_tag_p1.pc    <= TAG_PC_W'(pc_q[sel]);

            skid_tag_p1.valid <= skid_live;
            if (en && skid_live) begin
                if (!stall) begin
                    skid_tag_p1.valid <= 1'b0;
                    inst_valid        <= 1'b1;
                    inst_out          <= skid_data_p1;
                    inst_pc           <= skid_tag_p1.pc[INST_ADDR_WIDTH-1:0];
                    inst_tid          <= skid_tag_p1.tid[TW-1:0];
                end
            end else if (fl_live) begin
                if (stall) begin
                    skid_tag_p1 <= fl_tag_p1;
                end else begin
                    inst_valid <= 1'b1;
                    inst_out   <= mem_dout;
                    inst_pc    <= fl_tag_p1.pc[INST_ADDR_WIDTH-1:0];
                    inst_tid   <= fl_tag_p1.tid[TW-1:0];
                end
            end else if (en && !stall) begin
                inst_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fl_live && stall)
            skid_data_p1 <= mem_dout;
    end

endmodule

// File: tb/tb_fetch_stage_mt.sv
// Directed self-checking bench for fetch_stage_mt (default 4 threads, 9-bit PCs).
module tb_fetch_stage_mt;

    logic        clk, reset, en, stall;
    logic        redirect_valid;
    logic [1:0]  redirect_tid;
    logic [8:0]  redirect_pc;
    logic        dbg_req, dbg_we;
    logic [9:0]  dbg_addr;
    logic [63:0] dbg_wdata, dbg_rdata;
    logic        dbg_rvalid;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [63:0] mem_din, mem_dout;
    logic        inst_valid;
    logic [63:0] inst_out;
    logic [8:0]  inst_pc;
    logic [1:0]  inst_tid;
`ifdef ARYA_THREAD_MASK_EN
    logic [3:0]  thread_active = 4'hF;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage_mt dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .stall          (stall),
`ifdef ARYA_THREAD_MASK_EN
        .thread_active  (thread_active),
`endif
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_rdata      (dbg_rdata),
        .dbg_rvalid     (dbg_rvalid),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_tid       (inst_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed pattern of the address unless written by debug.
    function automatic logic [63:0] memval(input logic [9:0] a);
        return {16'hC0DE, 6'h00, a, 22'h0, a ^ 10'h2AA};
    endfunction

    logic [63:0]   wmem [1024];
    logic [1023:0] wvalid;

    always @(posedge clk or negedge reset) begin
        if (!reset) wvalid <= '0;
        else if (mem_we) begin
            wmem[mem_addr]   <= mem_din;
            wvalid[mem_addr] <= 1'b1;
        end
    end

    always @(posedge clk) mem_dout <= wvalid[mem_addr] ? wmem[mem_addr] : memval(mem_addr);

    task automatic idle_inputs();
        en = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_tid = 2'd0; redirect_pc = 9'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 10'h0; dbg_wdata = 64'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Leaves the bench just after reset release, inside cycle 0.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] pcs [6];
        logic [1:0] tids [6];
        pcs  = '{9'h000, 9'h080, 9'h100, 9'h180, 9'h001, 9'h081};
        tids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %0h want 0", inst_valid); end
        n_cmp++; if (inst_pc !== 9'h0) begin n_fail++; $display("FAIL reset_inst_pc got %0h want 0", inst_pc); end
        n_cmp++; if (inst_tid !== 2'd0) begin n_fail++; $display("FAIL reset_inst_tid got %0h want 0", inst_tid); end
        n_cmp++; if (inst_out !== 64'h0) begin n_fail++; $display("FAIL reset_inst_out got %0h want 0", inst_out); end
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_rvalid got %0h want 0", dbg_rvalid); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_first_addr got %0h want 0", mem_addr); end
        for (int i = 0; i < 8; i++) begin
            if (i < 2) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_early[%0d] got %0h want 0", i, inst_valid); end
            end else begin
                n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %0h want 1", i, inst_valid); end
                n_cmp++; if (inst_pc !== pcs[i-2]) begin n_fail++; $display("FAIL seq_pc[%0d] got %0h want %0h", i, inst_pc, pcs[i-2]); end
                n_cmp++; if (inst_tid !== tids[i-2]) begin n_fail++; $display("FAIL seq_tid[%0d] got %0h want %0h", i, inst_tid, tids[i-2]); end
                n_cmp++; if (inst_out !== memval({1'b0, pcs[i-2]})) begin n_fail++; $display("FAIL seq_data[%0d] got %0h want %0h", i, inst_out, memval({1'b0, pcs[i-2]})); end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        int         k;
        logic [8:0] want_pc;
        logic [1:0] want_tid;
        k = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            stall = (i >= 5 && i <= 7);
            #1;
            if (stall) begin
                n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 9'h180}) begin n_fail++; $display("FAIL stall_hold[%0d] got %0h want 380", i, {inst_valid, inst_pc}); end
            end
            if (inst_valid && !stall) begin
                want_tid = 2'(k % 4);
                want_pc  = 9'((k % 4) * 128 + k / 4);
                n_cmp++; if ({inst_tid, inst_pc} !== {want_tid, want_pc}) begin n_fail++; $display("FAIL stall_order[%0d] got tid %0h pc %0h want tid %0h pc %0h", k, inst_tid, inst_pc, want_tid, want_pc); end
                k++;
            end
            next_cycle();
        end
        stall = 1'b0;
        n_cmp++; if (k !== 14) begin n_fail++; $display("FAIL stall_count got %0d want 14", k); end
    endtask

    task automatic check_stream(input string name, input int i, input logic v, input logic [8:0] pc, input logic [1:0] tid);
        // Only stream-expectation plumbing; comparisons stay inline in each test.
    endtask

    task automatic test_redirect();
        logic       ev [10];
        logic [8:0] ep [10];
        logic [1:0] et [10];
        ev = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        ep = '{9'h0, 9'h0, 9'h000, 9'h080, 9'h0, 9'h180, 9'h001, 9'h081, 9'h040, 9'h181};
        et = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            redirect_valid = (i == 3);
            redirect_tid   = 2'd2;
            redirect_pc    = 9'h040;
            #1;
            n_cmp++; if (inst_valid !== ev[i]) begin n_fail++; $display("FAIL redir_valid[%0d] got %0h want %0h", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                n_cmp++; if ({inst_tid, inst_pc} !== {et[i], ep[i]}) begin n_fail++; $display("FAIL redir_inst[%0d] got tid %0h pc %0h want tid %0h pc %0h", i, inst_tid, inst_pc, et[i], ep[i]); end
            end
            if (i == 8) begin
                n_cmp++; if (inst_out !== memval(10'h040)) begin n_fail++; $display("FAIL redir_data got %0h want %0h", inst_out, memval(10'h040)); end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_redirect_selected();
        logic       ev [6];
        logic [8:0] ep [6];
        logic [1:0] et [6];
        ev = '{0, 0, 0, 1, 1, 1};
        ep = '{9'h0, 9'h0, 9'h0, 9'h010, 9'h080, 9'h100};
        et = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            redirect_valid = (i == 0);
            redirect_tid   = 2'd0;
            redirect_pc    = 9'h010;
            #1;
            n_cmp++; if (inst_valid !== ev[i]) begin n_fail++; $display("FAIL redsel_valid[%0d] got %0h want %0h", i, inst_valid, ev[i]); end
            if (ev[i]) begin
                n_cmp++; if ({inst_tid, inst_pc} !== {et[i], ep[i]}) begin n_fail++; $display("FAIL redsel_inst[%0d] got tid %0h pc %0h want tid %0h pc %0h", i, inst_tid, inst_pc, et[i], ep[i]); end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_debug();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dbg_req   = (i == 4 || i == 5);
            dbg_we    = (i == 4);
            dbg_addr  = 10'h3FF;
            dbg_wdata = 64'h0000_0000_DEAD_BEEF;
            #1;
            case (i)
                3: begin
                    n_cmp++; if (mem_addr !== 10'h180) begin n_fail++; $display("FAIL dbg_pre_addr got %0h want 180", mem_addr); end
                end
                4: begin
                    n_cmp++; if ({mem_we, mem_addr} !== {1'b1, 10'h3FF}) begin n_fail++; $display("FAIL dbg_wr_port got %0h want 7ff", {mem_we, mem_addr}); end
                    n_cmp++; if (mem_din !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dbg_wr_data got %0h want deadbeef", mem_din); end
                    n_cmp++; if (inst_pc !== 9'h100) begin n_fail++; $display("FAIL dbg_inst_c4 got %0h want 100", inst_pc); end
                end
                5: begin
                    n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 10'h3FF}) begin n_fail++; $display("FAIL dbg_rd_port got %0h want 3ff", {mem_we, mem_addr}); end
                    n_cmp++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_rvalid_after_wr got %0h want 0", dbg_rvalid); end
                    n_cmp++; if ({inst_valid, inst_pc} !== {1'b1, 9'h180}) begin n_fail++; $display("FAIL dbg_inst_c5 got %0h want 380", {inst_valid, inst_pc}); end
                end
                6: begin
                    n_cmp++; if (dbg_rvalid !== 1'b1) begin n_fail++; $display("FAIL dbg_rvalid got %0h want 1", dbg_rvalid); end
                    n_cmp++; if (dbg_rdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dbg_rdata got %0h want deadbeef", dbg_rdata); end
                    n_cmp++; if ({mem_we, mem_addr} !== {1'b0, 10'h001}) begin n_fail++; $display("FAIL dbg_resume_addr got %0h want 001", {mem_we, mem_addr}); end
                    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL dbg_bubble_c6 got %0h want 0", inst_valid); end
                end
                7: begin
                    n_cmp++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_rvalid_drop got %0h want 0", dbg_rvalid); end
                    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL dbg_bubble_c7 got %0h want 0", inst_valid); end
                end
                8: begin
                    n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd0, 9'h001}) begin n_fail++; $display("FAIL dbg_resume_c8 got %0h want 801", {inst_valid, inst_tid, inst_pc}); end
                end
                9: begin
                    n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd1, 9'h081}) begin n_fail++; $display("FAIL dbg_resume_c9 got %0h want a81", {inst_valid, inst_tid, inst_pc}); end
                end
                default: ;
            endcase
            next_cycle();
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            redirect_valid = (i == 0);
            redirect_tid   = 2'd3;
            redirect_pc    = 9'h1FF;
            #1;
            if (i == 5) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd3, 9'h1FF}) begin n_fail++; $display("FAIL wrap_top got %0h want fff", {inst_valid, inst_tid, inst_pc}); end
                n_cmp++; if (inst_out !== memval(10'h1FF)) begin n_fail++; $display("FAIL wrap_top_data got %0h want %0h", inst_out, memval(10'h1FF)); end
            end
            if (i == 6) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd0, 9'h001}) begin n_fail++; $display("FAIL wrap_next got %0h want 801", {inst_valid, inst_tid, inst_pc}); end
            end
            if (i == 9) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd3, 9'h000}) begin n_fail++; $display("FAIL wrap_zero got %0h want e00", {inst_valid, inst_tid, inst_pc}); end
                n_cmp++; if (inst_out !== memval(10'h000)) begin n_fail++; $display("FAIL wrap_zero_data got %0h want %0h", inst_out, memval(10'h000)); end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en = (i >= 3);
            #1;
            if (i <= 4) begin
                n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL en_idle[%0d] got %0h want 0", i, inst_valid); end
            end
            if (i == 5) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd0, 9'h000}) begin n_fail++; $display("FAIL en_first got %0h want 800", {inst_valid, inst_tid, inst_pc}); end
            end
            if (i == 6) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, 2'd1, 9'h080}) begin n_fail++; $display("FAIL en_second got %0h want a80", {inst_valid, inst_tid, inst_pc}); end
            end
            next_cycle();
        end
        en = 1'b1;
    endtask

`ifdef ARYA_THREAD_MASK_EN
    task automatic test_thread_mask();
        logic [8:0] ep [5];
        logic [1:0] et [5];
        ep = '{9'h000, 9'h100, 9'h001, 9'h101, 9'h002};
        et = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        thread_active = 4'b0101;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            #1;
            if (i >= 2) begin
                n_cmp++; if ({inst_valid, inst_tid, inst_pc} !== {1'b1, et[i-2], ep[i-2]}) begin n_fail++; $display("FAIL mask_seq[%0d] got tid %0h pc %0h want tid %0h pc %0h", i, inst_tid, inst_pc, et[i-2], ep[i-2]); end
            end
            next_cycle();
        end
        thread_active = 4'hF;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_selected();
        test_debug();
        test_wrap();
        test_enable();
`ifdef ARYA_THREAD_MASK_EN
        test_thread_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
